md_unit: RTL and testbench

- E-stage multiply/divide unit for the pipelined MIPS core.
- Executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo, and owns the HI/LO registers.
- Consumes the E-stage decoded MD opcode and forwarded rs/rt operands.
- Exports Busy, which the hazard unit ORs with Start to stall any D-stage MD instruction.

---
 rtl/md_unit.sv | 217 +++++++++++++++++++++
 tb/tb_md_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: executes mult/multu/div/divu/mthi/mtlo and serves mfhi/mflo reads from HI/LO.
// Latency: mthi/mtlo write on the accepting edge; mult/multu commit MULT_CYCLES edges later, div/divu DIV_CYCLES edges later.
// Backpressure: Busy is high during the multi-cycle period; a Start arriving while busy is ignored, and the hazard unit must stall it.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   counter;
    logic [31:0]     temp_hi;
    logic [31:0]     temp_lo;
    // Set when the pending operation was a divide by zero: the busy period still runs but nothing is committed.
    logic            temp_dz;

    // Control decoded from the current state and request.
    logic            accept_op;
    logic            last_cycle;
    logic            commit;
    logic            wr_mthi;
    logic            wr_mtlo;

    // Combinational result of the requested operation on the current operands.
    logic [31:0]     res_hi;
    logic [31:0]     res_lo;
    logic            res_dz;
    logic [CW-1:0]   res_cycles;

    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic            a_neg;
    logic            b_neg;
    logic [31:0]     a_mag;
    logic [31:0]     b_mag;
    logic [31:0]     sdiv_den;
    logic [31:0]     udiv_den;
    logic [31:0]     sq_mag;
    logic [31:0]     sr_mag;
    logic [31:0]     uq;
    logic [31:0]     ur;

    // Only the arithmetic opcodes (MDOp[2]==0) open a busy period.
    assign last_cycle = (counter == CW'(1));

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> BUSY on an accepted arithmetic op, BUSY -> IDLE on the final busy cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start && !MDOp[2]) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_cycle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode; Starts seen while BUSY produce no strobes at all.
    always_comb begin
        Busy      = 1'b0;
        accept_op = 1'b0;
        commit    = 1'b0;
        wr_mthi   = 1'b0;
        wr_mtlo   = 1'b0;
        case (state)
            IDLE: begin
                accept_op = Start && !MDOp[2];
                wr_mthi   = Start && (MDOp == OP_MTHI);
                wr_mtlo   = Start && (MDOp == OP_MTLO);
            end
            BUSY: begin
                Busy   = 1'b1;
                commit = last_cycle && !temp_dz;
            end
            default: ;
        endcase
    end

    // Signed division works on magnitudes so the quotient truncates toward zero and
    // the remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    // A zero divisor is swapped for 1 only to keep the divider defined; its result is discarded.
    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'd0, A} * {32'd0, B};
        a_neg    = A[31];
        b_neg    = B[31];
        a_mag    = a_neg ? (32'd0 - A) : A;
        b_mag    = b_neg ? (32'd0 - B) : B;
        sdiv_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        udiv_den = (B == 32'd0) ? 32'd1 : B;
        sq_mag   = a_mag / sdiv_den;
        sr_mag   = a_mag % sdiv_den;
        uq       = A / udiv_den;
        ur       = A % udiv_den;
    end

    // Select the result, divide-by-zero flag and busy length for the requested opcode.
    always_comb begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_dz     = 1'b0;
        res_cycles = CW'(MULT_CYCLES);
        case (MDOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_lo     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
                res_hi     = a_neg ? (32'd0 - sr_mag) : sr_mag;
                res_dz     = (B == 32'd0);
                res_cycles = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                res_lo     = uq;
                res_hi     = ur;
                res_dz     = (B == 32'd0);
                res_cycles = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Busy counter and pending result: loaded when an op is accepted, counted down while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            temp_dz <= 1'b0;
        end else if (accept_op) begin
            counter <= res_cycles;
            temp_hi <= res_hi;
            temp_lo <= res_lo;
            temp_dz <= res_dz;
        end else if (Busy) begin
            counter <= counter - CW'(1);
        end
    end

    // Architectural HI/LO: written by mthi/mtlo immediately or by the pending result on the last busy edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else begin
            if (commit) begin
                HI <= temp_hi;
                LO <= temp_lo;
            end
            if (wr_mthi) begin
                HI <= A;
            end
            if (wr_mtlo) begin
                LO <= A;
            end
        end
    end

    // Read port for mfhi/mflo; the hazard unit keeps these out of E while Busy.
    always_comb begin
        case (MDOp)
            OP_MFHI: Out = HI;
            OP_MFLO: Out = LO;
            default: Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed results, busy-period lengths, reset and ignored-Start cases.
// Inputs change #1 after a rising edge; outputs are sampled at that point or later within the cycle.
// Every busy wait is bounded; an overrun shows up as a cycle-count mismatch.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the architectural HI/LO contents.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one arithmetic op, count its busy cycles, check HI/LO are held until the final busy cycle and then updated.
    task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
        MDOp  = 3'd0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            if (n == exp_cycles) begin
                check({tag, "_hold_hi"}, HI, m_hi);
                check({tag, "_hold_lo"}, LO, m_lo);
            end
            step();
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic check_reads(input string tag);
        MDOp = 3'd6;
        #1;
        check({tag, "_mfhi"}, Out, m_hi);
        MDOp = 3'd7;
        #1;
        check({tag, "_mflo"}, Out, m_lo);
        MDOp = 3'd0;
        #1;
        check({tag, "_out_idle"}, Out, 32'd0);
    endtask

    initial begin
        int n;
        logic busy_seen;

        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        step();
        step();
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;
        step();

        // mtlo then mthi: written on the accepting edge with no busy period.
        Start = 1'b1; MDOp = 3'd5; A = 32'h1111_1111;
        step();
        check("mtlo_lo", LO, 32'h1111_1111);
        check("mtlo_busy", 32'(Busy), 32'd0);
        MDOp = 3'd4; A = 32'h1234_5678;
        step();
        Start = 1'b0; MDOp = 3'd0;
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_busy", 32'(Busy), 32'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h1111_1111;
        check_reads("mt");

        // Asynchronous reset mid-cycle clears HI/LO before any edge.
        #3;
        reset = 1'b1;
        #1;
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        step();
        reset = 1'b0;
        step();

        // Arithmetic, issued back to back as soon as Busy falls.
        md_op("mult",      3'd0, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        md_op("multu",     3'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'h0000_0002, 32'hFFFF_FFFA);
        md_op("div",       3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_op("divu_z",    3'd3, 32'd7,         32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        md_op("divu",      3'd3, 32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E);
        md_op("div_nd",    3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        md_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000);
        md_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
        md_op("div_z",     3'd2, 32'h0000_1234, 32'd0,        10, 32'hFFFF_FFFE, 32'h0000_0001);
        check_reads("arith");

        // Starts while BUSY (mthi, then divu) are ignored; the mult still lands on schedule.
        Start = 1'b1; MDOp = 3'd0; A = 32'd2; B = 32'd3;
        step();
        Start = 1'b0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            if (n == 2) begin
                Start = 1'b1; MDOp = 3'd4; A = 32'hDEAD_BEEF;
            end else if (n == 3) begin
                Start = 1'b1; MDOp = 3'd3; A = 32'd9; B = 32'd2;
            end else begin
                Start = 1'b0; MDOp = 3'd0;
            end
            step();
        end
        Start = 1'b0; MDOp = 3'd0;
        check("ign_cycles", 32'(n), 32'd5);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;
        step();
        check("ign_no_restart", 32'(Busy), 32'd0);

        // Load nonzero HI/LO, then reset in busy cycle 4 of a divide.
        md_op("pre_rst", 3'd1, 32'd10, 32'd10, 5, 32'd0, 32'd100);
        Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0; MDOp = 3'd0;
        step();
        step();
        step();
        check("mid_busy_c4", 32'(Busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        step();
        reset = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (Busy) busy_seen = 1'b1;
        end
        check("mid_no_busy", 32'(busy_seen), 32'd0);
        check("mid_late_hi", HI, 32'd0);
        check("mid_late_lo", LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
